// File: rtl/sensor_request_scheduler.sv
// sensor_request_scheduler: shares N sensor channels between host requests and continuous-mode polls
module sensor_request_scheduler #(
   parameter int N_SENSORS   = 4,
   parameter int POLL_PERIOD = 125000000,
   parameter int TIMEOUT     = 5000000
) (
   input  logic                   clock_i,
   input  logic                   reset_n_i,
   input  logic                   req_valid_i,
   input  logic [7:0]             req_command_i,
   input  logic [7:0]             req_address_i,
   output logic                   req_ready_o,
   output logic [N_SENSORS-1:0]   sensor_enable_o,
   output logic [7:0]             sensor_command_o,
   input  logic [N_SENSORS-1:0]   sensor_done_i,
   input  logic [8*N_SENSORS-1:0] sensor_rsp_cmd_i,
   input  logic [8*N_SENSORS-1:0] sensor_rsp_val_i,
   output logic                   resp_valid_o,
   output logic [7:0]             resp_command_o,
   output logic [7:0]             resp_value_o,
   input  logic                   resp_ready_i
);
   localparam int AW = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
   localparam int PW = $clog2(POLL_PERIOD + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] M_OFF = 2'd0, M_TEMP = 2'd1, M_HUM = 2'd2;
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_COOL} state_t;
   state_t                      state_q, state_d;
   logic                        pend_q, pend_d, due_q, due_d, is_poll_q, is_poll_d;
   logic [7:0]                  pcmd_q, pcmd_d, paddr_q, paddr_d, cmd_q, cmd_d;
   logic [7:0]                  rcmd_q, rcmd_d, rval_q, rval_d;
   logic [N_SENSORS-1:0][1:0]   mode_q, mode_d;
   logic [PW-1:0]               poll_q, poll_d;
   logic [TW-1:0]               to_q, to_d;
   logic [AW-1:0]               rr_q, rr_d, ch_q, ch_d, pick, idx, pa;
   logic                        any_on, poll_wrap;
   logic [7:0]                  done_cmd;
   assign pa        = paddr_q[AW-1:0];
   assign poll_wrap = (poll_q == PW'(POLL_PERIOD - 1));
   assign done_cmd  = sensor_rsp_cmd_i[{ch_q, 3'b000} +: 8];
   // Round-robin search for the first active address at or after rr_q
   always_comb begin
      any_on = 1'b0;
      pick   = rr_q;
      idx    = '0;
      for (int k = 0; k < N_SENSORS; k++) begin
         idx = AW'((int'(rr_q) + k) % N_SENSORS);
         if (!any_on && mode_q[idx] != M_OFF) begin
            pick   = idx;
            any_on = 1'b1;
         end
      end
   end
   // All state, asynchronously cleared so an aborted transaction vanishes without a response
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= S_IDLE;
         pend_q    <= 1'b0;
         due_q     <= 1'b0;
         is_poll_q <= 1'b0;
         pcmd_q    <= '0;
         paddr_q   <= '0;
         cmd_q     <= '0;
         rcmd_q    <= '0;
         rval_q    <= '0;
         mode_q    <= '0;
         poll_q    <= '0;
         to_q      <= '0;
         rr_q      <= '0;
         ch_q      <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         due_q     <= due_d;
         is_poll_q <= is_poll_d;
         pcmd_q    <= pcmd_d;
         paddr_q   <= paddr_d;
         cmd_q     <= cmd_d;
         rcmd_q    <= rcmd_d;
         rval_q    <= rval_d;
         mode_q    <= mode_d;
         poll_q    <= poll_d;
         to_q      <= to_d;
         rr_q      <= rr_d;
         ch_q      <= ch_d;
      end
   end
   // Next state: request decode, poll dispatch, wait for done/timeout, response handshake
   always_comb begin
      state_d   = state_q;
      pend_d    = pend_q;
      pcmd_d    = pcmd_q;
      paddr_d   = paddr_q;
      is_poll_d = is_poll_q;
      cmd_d     = cmd_q;
      rcmd_d    = rcmd_q;
      rval_d    = rval_q;
      mode_d    = mode_q;
      rr_d      = rr_q;
      ch_d      = ch_q;
      if (req_valid_i && !pend_q) begin
         pend_d  = 1'b1;
         pcmd_d  = req_command_i;
         paddr_d = req_address_i;
      end
      poll_d = poll_wrap ? '0 : poll_q + 1'b1;
      due_d  = due_q | poll_wrap;
      to_d   = to_q + 1'b1;
      case (state_q)
         S_IDLE: begin
            to_d = '0;
            if (pend_q) begin
               pend_d = 1'b0;
               if (paddr_q >= 8'(N_SENSORS)) begin
                  state_d = S_SEND;
                  rcmd_d  = 8'h45;
                  rval_d  = 8'h45;
               end else if (pcmd_q == 8'h03 || pcmd_q == 8'h04) begin
                  mode_d[pa] = (pcmd_q == 8'h03) ? M_TEMP : M_HUM;
               end else if (pcmd_q == 8'h05 || pcmd_q == 8'h06) begin
                  state_d = S_SEND;
                  if (mode_q[pa] == ((pcmd_q == 8'h05) ? M_TEMP : M_HUM)) begin
                     mode_d[pa] = M_OFF;
                     rcmd_d     = (pcmd_q == 8'h05) ? 8'h0A : 8'h0B;
                  end else begin
                     rcmd_d = 8'hAA;
                  end
                  rval_d = rcmd_d;
               end else if (mode_q[pa] != M_OFF) begin
                  state_d = S_SEND;
                  rcmd_d  = 8'hFF;
                  rval_d  = 8'hFF;
               end else begin
                  state_d   = S_WAIT;
                  ch_d      = pa;
                  cmd_d     = pcmd_q;
                  is_poll_d = 1'b0;
               end
            end else if (due_q && any_on) begin
               due_d     = 1'b0;
               rr_d      = (pick == AW'(N_SENSORS - 1)) ? '0 : pick + 1'b1;
               ch_d      = pick;
               cmd_d     = (mode_q[pick] == M_TEMP) ? 8'h01 : 8'h02;
               is_poll_d = 1'b1;
               state_d   = S_WAIT;
            end
         end
         S_WAIT: begin
            if (sensor_done_i[ch_q]) begin
               state_d = S_SEND;
               rcmd_d  = !is_poll_q ? done_cmd : (done_cmd == 8'h09) ? 8'h0D : (done_cmd == 8'h08) ? 8'h0E : done_cmd;
               rval_d  = sensor_rsp_val_i[{ch_q, 3'b000} +: 8];
            end else if (to_q == TW'(TIMEOUT - 1)) begin
               state_d = S_SEND;
               rcmd_d  = 8'h1F;
               rval_d  = 8'h1F;
            end
         end
         S_SEND: state_d = resp_ready_i ? S_COOL : S_SEND;
         default: state_d = S_IDLE;
      endcase
   end
   // Outputs decoded from state; enables and response bytes are zero outside their phases
   always_comb begin
      sensor_enable_o = '0;
      if (state_q == S_WAIT) sensor_enable_o[ch_q] = 1'b1;
      sensor_command_o = (state_q == S_WAIT) ? cmd_q : 8'h00;
      resp_valid_o     = (state_q == S_SEND);
      resp_command_o   = (state_q == S_SEND) ? rcmd_q : 8'h00;
      resp_value_o     = (state_q == S_SEND) ? rval_q : 8'h00;
      req_ready_o      = !pend_q;
   end
endmodule

// File: tb/tb_sensor_request_scheduler.sv
// tb_sensor_request_scheduler: scoreboard bench for the sensor request scheduler
module tb_sensor_request_scheduler;
   localparam int N = 4;
   logic           clock_i = 1'b0;
   logic           reset_n_i = 1'b0;
   logic           req_valid_i = 1'b0;
   logic [7:0]     req_command_i = '0;
   logic [7:0]     req_address_i = '0;
   logic           req_ready_o;
   logic [N-1:0]   sensor_enable_o;
   logic [7:0]     sensor_command_o;
   logic [N-1:0]   sensor_done_i = '0;
   logic [8*N-1:0] sensor_rsp_cmd_i = '0;
   logic [8*N-1:0] sensor_rsp_val_i = '0;
   logic           resp_valid_o;
   logic [7:0]     resp_command_o;
   logic [7:0]     resp_value_o;
   logic           resp_ready_i = 1'b1;
   int             checks = 0;
   int             errors = 0;
   int             cyc = 0;
   logic [15:0]    exp_q[$];
   logic [15:0]    mon_e;

   sensor_request_scheduler #(.N_SENSORS(N), .POLL_PERIOD(100), .TIMEOUT(50)) dut (
      .clock_i(clock_i), .reset_n_i(reset_n_i),
      .req_valid_i(req_valid_i), .req_command_i(req_command_i), .req_address_i(req_address_i),
      .req_ready_o(req_ready_o),
      .sensor_enable_o(sensor_enable_o), .sensor_command_o(sensor_command_o),
      .sensor_done_i(sensor_done_i), .sensor_rsp_cmd_i(sensor_rsp_cmd_i), .sensor_rsp_val_i(sensor_rsp_val_i),
      .resp_valid_o(resp_valid_o), .resp_command_o(resp_command_o), .resp_value_o(resp_value_o),
      .resp_ready_i(resp_ready_i)
   );

   always #5 clock_i = ~clock_i;

   // Cycles since reset release; the poll tick lands on every multiple of 100
   always @(posedge clock_i or negedge reset_n_i)
      if (!reset_n_i) cyc <= 0;
      else cyc <= cyc + 1;

   // Scoreboard: every handshaken response must match the oldest expectation
   always @(negedge clock_i) begin
      if (reset_n_i && resp_valid_o && resp_ready_i) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL resp_unexpected: got %h/%h, required no response", resp_command_o, resp_value_o);
         end else begin
            mon_e = exp_q.pop_front();
            if ({resp_command_o, resp_value_o} !== mon_e) begin
               errors++;
               $display("FAIL resp_data: got %h/%h, required %h/%h", resp_command_o, resp_value_o, mon_e[15:8], mon_e[7:0]);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic do_reset();
      reset_n_i = 1'b0;
      req_valid_i = 1'b0;
      sensor_done_i = '0;
      resp_ready_i = 1'b1;
      repeat (3) @(posedge clock_i);
      #1 reset_n_i = 1'b1;
   endtask

   task automatic expect_resp(input logic [7:0] c, input logic [7:0] v);
      exp_q.push_back({c, v});
   endtask

   task automatic send_req(input logic [7:0] c, input logic [7:0] a);
      int n = 0;
      @(negedge clock_i);
      while (!req_ready_o && n < 500) begin
         @(negedge clock_i);
         n++;
      end
      checks++;
      if (req_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL req_ready_wait: got %b after %0d cycles, required 1", req_ready_o, n);
      end
      req_valid_i = 1'b1;
      req_command_i = c;
      req_address_i = a;
      @(posedge clock_i);
      #1 req_valid_i = 1'b0;
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc != target && n < 1000) begin
         @(negedge clock_i);
         n++;
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         @(negedge clock_i);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clock_i);
   endtask

   // Wait for channel ch to be enabled, then pulse its done d cycles later with c/v
   task automatic respond(input int ch, input int d, input logic [7:0] c, input logic [7:0] v,
                          output int lat, output logic [N-1:0] en, output logic [7:0] cmd, output int at);
      lat = 0;
      do begin
         @(negedge clock_i);
         lat++;
      end while (!sensor_enable_o[ch] && lat < 1000);
      en = sensor_enable_o;
      cmd = sensor_command_o;
      at = cyc;
      checks++;
      if (!sensor_enable_o[ch]) begin
         errors++;
         $display("FAIL enable_wait ch%0d: got enable %b, required bit set", ch, sensor_enable_o);
         return;
      end
      if (d > 0) begin
         repeat (d) @(posedge clock_i);
         #1;
      end
      sensor_rsp_cmd_i[ch*8 +: 8] = c;
      sensor_rsp_val_i[ch*8 +: 8] = v;
      sensor_done_i[ch] = 1'b1;
      @(posedge clock_i);
      #1 sensor_done_i = '0;
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      #2;
      checks += 5;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b, required 1", req_ready_o); end
      if (sensor_enable_o !== '0) begin errors++; $display("FAIL reset_enable: got %b, required 0", sensor_enable_o); end
      if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b, required 0", resp_valid_o); end
      if (sensor_command_o !== 8'h00) begin errors++; $display("FAIL reset_sensor_cmd: got %h, required 00", sensor_command_o); end
      if ({resp_command_o, resp_value_o} !== 16'h0000) begin errors++; $display("FAIL reset_resp_bytes: got %h/%h, required 00/00", resp_command_o, resp_value_o); end
      do_reset();
      repeat (3) @(negedge clock_i);
      checks += 2;
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL idle_req_ready: got %b, required 1", req_ready_o); end
      if (sensor_enable_o !== '0) begin errors++; $display("FAIL idle_enable: got %b, required 0", sensor_enable_o); end
   endtask

   task automatic test_host_read();
      int lat, at;
      logic [N-1:0] en;
      logic [7:0] cmd;
      expect_resp(8'h09, 8'h19);
      send_req(8'h01, 8'h01);
      checks++;
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL t1_ready_drop: got %b, required 0", req_ready_o); end
      respond(1, 5, 8'h09, 8'h19, lat, en, cmd, at);
      checks += 3;
      if (lat !== 2) begin errors++; $display("FAIL t1_enable_latency: got %0d, required 2", lat); end
      if (en !== 4'b0010) begin errors++; $display("FAIL t1_enable: got %b, required 0010", en); end
      if (cmd !== 8'h01) begin errors++; $display("FAIL t1_command: got %h, required 01", cmd); end
      drain("t1");
      checks++;
      if (sensor_enable_o !== '0) begin errors++; $display("FAIL t1_enable_after: got %b, required 0", sensor_enable_o); end
   endtask

   task automatic test_errors();
      int n = 0;
      int seen = 0;
      do_reset();
      expect_resp(8'h45, 8'h45);
      send_req(8'h02, 8'h07);
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clock_i);
         if (sensor_enable_o !== '0) seen++;
         n++;
      end
      checks += 2;
      if (exp_q.size() != 0) begin errors++; $display("FAIL t2_bad_addr_resp: %0d outstanding, required 0", exp_q.size()); exp_q.delete(); end
      if (seen !== 0) begin errors++; $display("FAIL t2_no_enable: got %0d enabled cycles, required 0", seen); end
      send_req(8'h04, 8'h00);
      expect_resp(8'hFF, 8'hFF);
      send_req(8'h01, 8'h00);
      drain("t2_busy");
      expect_resp(8'h0B, 8'h0B);
      send_req(8'h06, 8'h00);
      drain("t2_clear");
   endtask

   task automatic test_poll();
      int lat, at, ch;
      logic [N-1:0] en;
      logic [7:0] cmd, code, rsp;
      do_reset();
      send_req(8'h03, 8'h00);
      send_req(8'h04, 8'h02);
      for (int r = 0; r < 3; r++) begin
         ch = (r == 1) ? 2 : 0;
         code = (r == 0) ? 8'h09 : (r == 1) ? 8'h08 : 8'h77;
         rsp = (r == 0) ? 8'h0D : (r == 1) ? 8'h0E : 8'h77;
         expect_resp(rsp, 8'h30 + 8'(r));
         respond(ch, 3, code, 8'h30 + 8'(r), lat, en, cmd, at);
         checks += 3;
         if (en !== (4'b0001 << ch)) begin errors++; $display("FAIL t3_poll%0d_enable: got %b, required ch%0d", r, en, ch); end
         if (cmd !== ((ch == 0) ? 8'h01 : 8'h02)) begin errors++; $display("FAIL t3_poll%0d_cmd: got %h, required %h", r, cmd, (ch == 0) ? 8'h01 : 8'h02); end
         if (at !== 100 * (r + 1) + 1) begin errors++; $display("FAIL t3_poll%0d_time: got %0d, required %0d", r, at, 100 * (r + 1) + 1); end
         drain("t3");
      end
      expect_resp(8'h0A, 8'h0A);
      send_req(8'h05, 8'h00);
      expect_resp(8'h0B, 8'h0B);
      send_req(8'h06, 8'h02);
      drain("t3_stop");
   endtask

   task automatic test_priority();
      int lat, at, seen;
      logic [N-1:0] en;
      logic [7:0] cmd;
      do_reset();
      send_req(8'h03, 8'h00);
      wait_cyc(98);
      expect_resp(8'h09, 8'h12);
      send_req(8'h07, 8'h01);
      respond(1, 2, 8'h09, 8'h12, lat, en, cmd, at);
      checks += 3;
      if (en !== 4'b0010) begin errors++; $display("FAIL t4_host_first: got %b, required 0010", en); end
      if (cmd !== 8'h07) begin errors++; $display("FAIL t4_host_cmd: got %h, required 07", cmd); end
      if (at !== 101) begin errors++; $display("FAIL t4_host_time: got %0d, required 101", at); end
      expect_resp(8'h0D, 8'h21);
      respond(0, 2, 8'h09, 8'h21, lat, en, cmd, at);
      checks += 2;
      if (en !== 4'b0001) begin errors++; $display("FAIL t4_poll_next: got %b, required 0001", en); end
      if (cmd !== 8'h01) begin errors++; $display("FAIL t4_poll_cmd: got %h, required 01", cmd); end
      drain("t4");
      expect_resp(8'hAA, 8'hAA);
      send_req(8'h06, 8'h00);
      expect_resp(8'h0A, 8'h0A);
      send_req(8'h05, 8'h00);
      drain("t4_clear");
      seen = 0;
      repeat (250) begin
         @(negedge clock_i);
         if (sensor_enable_o !== '0) seen++;
      end
      checks++;
      if (seen !== 0) begin errors++; $display("FAIL t4_polls_stop: got %0d enabled cycles, required 0", seen); end
   endtask

   task automatic test_timeout();
      int n, cnt, lat, at;
      logic [N-1:0] en;
      logic [7:0] cmd;
      expect_resp(8'h1F, 8'h1F);
      send_req(8'h01, 8'h03);
      n = 0;
      do begin
         @(negedge clock_i);
         n++;
      end while (!sensor_enable_o[3] && n < 100);
      cnt = 0;
      while (sensor_enable_o[3] && cnt < 200) begin
         cnt++;
         @(negedge clock_i);
      end
      checks++;
      if (cnt !== 50) begin errors++; $display("FAIL t5_timeout_len: got %0d, required 50", cnt); end
      drain("t5_timeout");
      expect_resp(8'h5A, 8'h6B);
      send_req(8'h01, 8'h03);
      fork
         respond(3, 49, 8'h5A, 8'h6B, lat, en, cmd, at);
         begin
            repeat (6) @(posedge clock_i);
            #1;
            sensor_rsp_cmd_i[23:16] = 8'hEE;
            sensor_rsp_val_i[23:16] = 8'hEE;
            sensor_done_i[2] = 1'b1;
            @(posedge clock_i);
            #1 sensor_done_i[2] = 1'b0;
         end
      join
      checks++;
      if (en !== 4'b1000) begin errors++; $display("FAIL t5_enable: got %b, required 1000", en); end
      drain("t5_tie");
   endtask

   task automatic test_back_to_back();
      int lat, at, bad, n;
      logic [N-1:0] en;
      logic [7:0] cmd;
      do_reset();
      resp_ready_i = 1'b0;
      expect_resp(8'h11, 8'h22);
      send_req(8'h01, 8'h01);
      respond(1, 1, 8'h11, 8'h22, lat, en, cmd, at);
      expect_resp(8'h33, 8'h44);
      send_req(8'h02, 8'h02);
      bad = 0;
      repeat (20) begin
         @(negedge clock_i);
         if (resp_valid_o !== 1'b1 || resp_command_o !== 8'h11 || resp_value_o !== 8'h22) bad++;
      end
      checks += 2;
      if (bad !== 0) begin errors++; $display("FAIL t6_hold_stable: got %0d unstable cycles, required 0", bad); end
      if (req_ready_o !== 1'b0) begin errors++; $display("FAIL t6_pending_held: got %b, required 0", req_ready_o); end
      @(posedge clock_i);
      #1 resp_ready_i = 1'b1;
      respond(2, 1, 8'h33, 8'h44, lat, en, cmd, at);
      checks += 2;
      if (en !== 4'b0100) begin errors++; $display("FAIL t6_second_enable: got %b, required 0100", en); end
      if (cmd !== 8'h02) begin errors++; $display("FAIL t6_second_cmd: got %h, required 02", cmd); end
      drain("t6");
      send_req(8'h03, 8'h00);
      send_req(8'h01, 8'h01);
      n = 0;
      while (!sensor_enable_o[1] && n < 50) begin
         @(negedge clock_i);
         n++;
      end
      @(posedge clock_i);
      #3 reset_n_i = 1'b0;
      #1;
      checks += 4;
      if (sensor_enable_o !== '0) begin errors++; $display("FAIL t6_async_enable: got %b, required 0", sensor_enable_o); end
      if (sensor_command_o !== 8'h00) begin errors++; $display("FAIL t6_async_cmd: got %h, required 00", sensor_command_o); end
      if (resp_valid_o !== 1'b0) begin errors++; $display("FAIL t6_async_resp: got %b, required 0", resp_valid_o); end
      if (req_ready_o !== 1'b1) begin errors++; $display("FAIL t6_async_ready: got %b, required 1", req_ready_o); end
      repeat (2) @(posedge clock_i);
      #1 reset_n_i = 1'b1;
      expect_resp(8'h09, 8'h01);
      send_req(8'h01, 8'h00);
      respond(0, 1, 8'h09, 8'h01, lat, en, cmd, at);
      checks++;
      if (en !== 4'b0001) begin errors++; $display("FAIL t6_mode_cleared: got %b, required 0001", en); end
      drain("t6_after_reset");
   endtask

   initial begin
      test_reset();
      test_host_read();
      test_errors();
      test_poll();
      test_priority();
      test_timeout();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
